// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multicycle processor datapath.
// Steps each instruction through fetch, decode, execute, memory and writeback.
// It drives the memory handshake, the datapath mux selects, the write enables and the
// immediate-extend selector.
// Ports:
//   clk, rst          rising-edge clock; synchronous active-high reset
//   op, is_load       instruction class (00 DP, 01 MEM, 10 BRANCH, 11 illegal) and L bit
//   cond_ex           condition check result, sampled in DECODE
//   mem_ready         memory completes the current request this cycle
//   mem_req/mem_write memory request and store qualifier
//   addr_src          memory address select (0 PC, 1 ALU result register)
//   ir_write/pc_write instruction-register and PC load enables; pc_src selects the PC source
//   imm_src           registered extend-unit selector (00 DP, 01 MEM, 10 BRANCH)
//   alu_src           ALU B operand select (0 register B, 1 immediate)
//   reg_write         register-file write enable; result_src selects the writeback source
//   fault             one-cycle pulse on an illegal op or a memory timeout
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] op,
  input  logic       is_load,
  input  logic       cond_ex,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       addr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [1:0] imm_src,
  output logic       alu_src,
  output logic       reg_write,
  output logic       result_src,
  output logic       fault
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] S_FETCH    = 3'd0;
  localparam logic [2:0] S_DECODE   = 3'd1;
  localparam logic [2:0] S_EXEC_DP  = 3'd2;
  localparam logic [2:0] S_MEM_ADDR = 3'd3;
  localparam logic [2:0] S_MEM_ACC  = 3'd4;
  localparam logic [2:0] S_WB_ALU   = 3'd5;
  localparam logic [2:0] S_WB_MEM   = 3'd6;
  localparam logic [2:0] S_BRANCH   = 3'd7;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       imm_q;
  logic             timeout;

  // State, wait counter and extend-selector registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      cnt   <= '0;
      imm_q <= 2'b00;
    end else begin
      state <= state_next;
      // Counting only while a request is stalled keeps the counter at zero on entry to
      // FETCH/MEM_ACC, since every path into those states leaves through a reset of cnt.
      if (mem_req && !mem_ready && !timeout) cnt <= cnt + CNT_W'(1);
      else                                   cnt <= '0;
      if (state == S_DECODE) imm_q <= (op == 2'b11) ? 2'b00 : op;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    addr_src   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    imm_src    = imm_q;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    result_src = 1'b0;
    fault      = 1'b0;
    timeout    = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (cnt == CNT_LAST) begin
          timeout    = 1'b1;
          fault      = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (op == 2'b11) begin
          fault      = 1'b1;
          state_next = S_FETCH;
        end else if (!cond_ex) begin
          state_next = S_FETCH;
        end else begin
          case (op)
            2'b00:   state_next = S_EXEC_DP;
            2'b01:   state_next = S_MEM_ADDR;
            2'b10:   state_next = S_BRANCH;
            default: state_next = S_FETCH;
          endcase
        end
      end
      S_EXEC_DP: begin
        alu_src    = 1'b1;
        state_next = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src    = 1'b1;
        state_next = S_MEM_ACC;
      end
      S_MEM_ACC: begin
        mem_req   = 1'b1;
        addr_src  = 1'b1;
        mem_write = ~is_load;
        if (mem_ready) begin
          state_next = is_load ? S_WB_MEM : S_FETCH;
        end else if (cnt == CNT_LAST) begin
          timeout    = 1'b1;
          fault      = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        result_src = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src    = 1'b1;
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    // Reset cycle: abandon any access and keep every output quiet
    if (rst) begin
      state_next = S_FETCH;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      addr_src   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      imm_src    = 2'b00;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      result_src = 1'b0;
      fault      = 1'b0;
      timeout    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed table, corner-case sequences and randomized instruction
// stream for multicycle_ctrl, checked cycle by cycle against expected output records.
module tb_multicycle_ctrl;

  localparam int unsigned MT = 4;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       addr_src;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       reg_write;
    logic       result_src;
    logic       fault;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [1:0] op;
    logic       is_load;
    logic       cond_ex;
    logic       mem_ready;
    outs_t      exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] op = 2'b00;
  logic       is_load = 1'b0;
  logic       cond_ex = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, addr_src, ir_write, pc_write, pc_src;
  logic [1:0] imm_src;
  logic       alu_src, reg_write, result_src, fault;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [1:0] imm_m = 2'b00;
  vec_t tbl[$];

  multicycle_ctrl #(.MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst), .op(op), .is_load(is_load), .cond_ex(cond_ex),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .addr_src(addr_src), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .imm_src(imm_src), .alu_src(alu_src), .reg_write(reg_write),
    .result_src(result_src), .fault(fault)
  );

  always #5 clk = ~clk;

  // Expected-output builders, one per kind of cycle
  function automatic outs_t o_idle(input logic [1:0] imm, input logic flt);
    outs_t e = '0;
    e.imm_src = imm;
    e.fault   = flt;
    return e;
  endfunction

  function automatic outs_t o_fetch(input logic rdy, input logic [1:0] imm, input logic flt);
    outs_t e = '0;
    e.mem_req  = 1'b1;
    e.ir_write = rdy;
    e.pc_write = rdy;
    e.imm_src  = imm;
    e.fault    = flt;
    return e;
  endfunction

  function automatic outs_t o_acc(input logic wr, input logic [1:0] imm, input logic flt);
    outs_t e = '0;
    e.mem_req   = 1'b1;
    e.mem_write = wr;
    e.addr_src  = 1'b1;
    e.imm_src   = imm;
    e.fault     = flt;
    return e;
  endfunction

  function automatic outs_t o_alu(input logic [1:0] imm);
    outs_t e = '0;
    e.alu_src = 1'b1;
    e.imm_src = imm;
    return e;
  endfunction

  function automatic outs_t o_br(input logic [1:0] imm);
    outs_t e = '0;
    e.alu_src  = 1'b1;
    e.pc_write = 1'b1;
    e.pc_src   = 1'b1;
    e.imm_src  = imm;
    return e;
  endfunction

  function automatic outs_t o_wb(input logic [1:0] imm, input logic res);
    outs_t e = '0;
    e.reg_write  = 1'b1;
    e.result_src = res;
    e.imm_src    = imm;
    return e;
  endfunction

  function automatic void add(input logic r, input logic [1:0] o, input logic ld,
                              input logic c, input logic rdy, input outs_t e);
    vec_t v;
    v.rst = r; v.op = o; v.is_load = ld; v.cond_ex = c; v.mem_ready = rdy; v.exp = e;
    tbl.push_back(v);
  endfunction

  // Apply one cycle of inputs, compare outputs mid-cycle, advance past the next edge
  task automatic step(input logic r, input logic [1:0] o, input logic ld, input logic c,
                      input logic rdy, input outs_t e, input string nm);
    outs_t act;
    rst = r; op = o; is_load = ld; cond_ex = c; mem_ready = rdy;
    @(negedge clk);
    act = {mem_req, mem_write, addr_src, ir_write, pc_write, pc_src, imm_src,
           alu_src, reg_write, result_src, fault};
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", nm, cyc, act, e);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Reference model: one whole instruction from the specification's sequencing rules
  task automatic rand_instr();
    logic [1:0] rop;
    logic rld, rc, rdy;
    rop = 2'($urandom_range(0, 3));
    rld = 1'($urandom_range(0, 1));
    rc  = ($urandom_range(0, 3) != 0);
    for (int k = 0; k < int'(MT); k++) begin
      rdy = ($urandom_range(0, 2) == 0);
      step(1'b0, rop, rld, rc, rdy, o_fetch(rdy, imm_m, !rdy && k == int'(MT) - 1), "rand_fetch");
      if (rdy) break;
      if (k == int'(MT) - 1) return;
    end
    step(1'b0, rop, rld, rc, 1'($urandom), o_idle(imm_m, rop == 2'b11), "rand_decode");
    imm_m = (rop == 2'b11) ? 2'b00 : rop;
    if (rop == 2'b11 || !rc) return;
    case (rop)
      2'b00: begin
        step(1'b0, rop, rld, rc, 1'($urandom), o_alu(imm_m), "rand_exec");
        step(1'b0, rop, rld, rc, 1'($urandom), o_wb(imm_m, 1'b0), "rand_wb_alu");
      end
      2'b10: step(1'b0, rop, rld, rc, 1'($urandom), o_br(imm_m), "rand_branch");
      default: begin
        step(1'b0, rop, rld, rc, 1'($urandom), o_alu(imm_m), "rand_mem_addr");
        for (int k = 0; k < int'(MT); k++) begin
          rdy = ($urandom_range(0, 1) == 0);
          step(1'b0, rop, rld, rc, rdy, o_acc(!rld, imm_m, !rdy && k == int'(MT) - 1), "rand_mem_acc");
          if (rdy) begin
            if (rld) step(1'b0, rop, rld, rc, 1'($urandom), o_wb(imm_m, 1'b1), "rand_wb_mem");
            break;
          end
        end
      end
    endcase
  endtask

  initial begin
    // Reset, then DP instruction with immediate memory
    add(1, 2'b00, 0, 1, 1, o_idle(2'b00, 0));
    add(1, 2'b00, 0, 1, 1, o_idle(2'b00, 0));
    add(0, 2'b00, 0, 1, 1, o_fetch(1, 2'b00, 0));
    add(0, 2'b00, 0, 1, 1, o_idle(2'b00, 0));
    add(0, 2'b00, 0, 1, 1, o_alu(2'b00));
    add(0, 2'b00, 0, 1, 1, o_wb(2'b00, 0));
    // Load with mem_ready arriving on the fourth MEM_ACC cycle
    add(0, 2'b01, 1, 1, 1, o_fetch(1, 2'b00, 0));
    add(0, 2'b01, 1, 1, 1, o_idle(2'b00, 0));
    add(0, 2'b01, 1, 1, 1, o_alu(2'b01));
    add(0, 2'b01, 1, 1, 0, o_acc(0, 2'b01, 0));
    add(0, 2'b01, 1, 1, 0, o_acc(0, 2'b01, 0));
    add(0, 2'b01, 1, 1, 0, o_acc(0, 2'b01, 0));
    add(0, 2'b01, 1, 1, 1, o_acc(0, 2'b01, 0));
    add(0, 2'b01, 1, 1, 1, o_wb(2'b01, 1));
    // Taken branch, then squashed branch
    add(0, 2'b10, 0, 1, 1, o_fetch(1, 2'b01, 0));
    add(0, 2'b10, 0, 1, 1, o_idle(2'b01, 0));
    add(0, 2'b10, 0, 1, 1, o_br(2'b10));
    add(0, 2'b10, 0, 0, 1, o_fetch(1, 2'b10, 0));
    add(0, 2'b10, 0, 0, 1, o_idle(2'b10, 0));
    // Illegal op faults in DECODE and clears the extend selector
    add(0, 2'b11, 0, 1, 1, o_fetch(1, 2'b10, 0));
    add(0, 2'b11, 0, 1, 1, o_idle(2'b10, 1));
    // Store with immediate memory
    add(0, 2'b01, 0, 1, 1, o_fetch(1, 2'b00, 0));
    add(0, 2'b01, 0, 1, 1, o_idle(2'b00, 0));
    add(0, 2'b01, 0, 1, 1, o_alu(2'b01));
    add(0, 2'b01, 0, 1, 1, o_acc(1, 2'b01, 0));

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].op, tbl[i].is_load, tbl[i].cond_ex, tbl[i].mem_ready,
           tbl[i].exp, $sformatf("vec%0d", i));

    // Fetch timeout, then a fetch whose ready lands on the last allowed cycle
    for (int k = 0; k < int'(MT); k++)
      step(0, 2'b00, 0, 1, 0, o_fetch(0, 2'b01, k == int'(MT) - 1), "fetch_timeout");
    for (int k = 0; k < int'(MT); k++)
      step(0, 2'b00, 0, 1, k == int'(MT) - 1, o_fetch(k == int'(MT) - 1, 2'b01, 0), "fetch_late_ready");
    step(0, 2'b00, 0, 1, 0, o_idle(2'b01, 0), "late_decode");
    step(0, 2'b00, 0, 1, 0, o_alu(2'b00), "late_exec");
    step(0, 2'b00, 0, 1, 0, o_wb(2'b00, 0), "late_wb");

    // Load that times out in MEM_ACC: fault, no register write, back to FETCH
    step(0, 2'b01, 1, 1, 1, o_fetch(1, 2'b00, 0), "acc_to_fetch");
    step(0, 2'b01, 1, 1, 0, o_idle(2'b00, 0), "acc_to_decode");
    step(0, 2'b01, 1, 1, 0, o_alu(2'b01), "acc_to_addr");
    for (int k = 0; k < int'(MT); k++)
      step(0, 2'b01, 1, 1, 0, o_acc(0, 2'b01, k == int'(MT) - 1), "acc_timeout");
    step(0, 2'b01, 1, 1, 0, o_fetch(0, 2'b01, 0), "acc_to_after");
    step(0, 2'b01, 0, 1, 1, o_fetch(1, 2'b01, 0), "rst_store_fetch");

    // Reset asserted during a store access
    step(0, 2'b01, 0, 1, 0, o_idle(2'b01, 0), "rst_store_decode");
    step(0, 2'b01, 0, 1, 0, o_alu(2'b01), "rst_store_addr");
    step(1, 2'b01, 0, 1, 1, o_idle(2'b00, 0), "rst_store_acc");
    step(0, 2'b01, 0, 1, 0, o_fetch(0, 2'b00, 0), "rst_store_after");

    // Randomized instruction stream from a fresh reset
    step(1, 2'b00, 0, 0, 0, o_idle(2'b00, 0), "rand_reset");
    imm_m = 2'b00;
    for (int n = 0; n < 400; n++) rand_instr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
